// File: rtl/bcd_tally_display.sv
// bcd_tally_display: tallies decade-counter wraps into a tens digit and multiplexes both digits onto a 7-segment output
module bcd_tally_display #(
    parameter int REFRESH_DIV = 4,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic [3:0] bcd_in,
    output logic [6:0] seg,
    output logic       dig_sel,
    output logic [3:0] tens,
    output logic       carry_out,
    output logic       err
);
    logic [3:0] cur_q, prev_q, tens_q, tens_d;
    logic       pv_q, pv_d, carry_q, carry_d, err_q, err_d, dig_sel_q, dig_sel_d;
    logic [7:0] rcnt_q, rcnt_d;
    logic [6:0] seg_q, seg_d;
    logic [4:0] prev_p1;
    logic [3:0] succ;
    logic       bad, wrap, last;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h79;
        endcase
    endfunction

    // Sequence checking, tally, refresh timing and segment selection
    always_comb begin
        prev_p1   = {1'b0, prev_q} + 5'd1;
        succ      = prev_p1 >= 5'd10 ? 4'(prev_p1 - 5'd10) : prev_p1[3:0];
        bad       = (cur_q > 4'd9) | (pv_q & (cur_q != prev_q) & (cur_q != succ));
        wrap      = pv_q & (prev_q == 4'd9) & (cur_q == 4'd0) & ~bad;
        tens_d    = clr ? 4'd0 : (wrap & ~err_q) ? (tens_q == 4'd9 ? 4'd0 : tens_q + 4'd1) : tens_q;
        carry_d   = ~clr & wrap & ~err_q & (tens_q == 4'd9);
        err_d     = ~clr & (err_q | bad);
        pv_d      = ~clr;
        last      = rcnt_q == 8'(REFRESH_DIV - 1);
        rcnt_d    = last ? 8'd0 : rcnt_q + 8'd1;
        dig_sel_d = dig_sel_q ^ last;
        seg_d     = err_q ? 7'h79 :
                    !dig_sel_q ? enc(cur_q) :
                    (BLANK_LZ && tens_q == 4'd0) ? 7'h00 : enc(tens_q);
    end

    // State registers; clr acts through the next-state terms above
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q     <= 4'd0;
            prev_q    <= 4'd0;
            pv_q      <= 1'b0;
            tens_q    <= 4'd0;
            carry_q   <= 1'b0;
            err_q     <= 1'b0;
            rcnt_q    <= 8'd0;
            dig_sel_q <= 1'b0;
            seg_q     <= 7'h00;
        end else begin
            cur_q     <= bcd_in;
            prev_q    <= cur_q;
            pv_q      <= pv_d;
            tens_q    <= tens_d;
            carry_q   <= carry_d;
            err_q     <= err_d;
            rcnt_q    <= rcnt_d;
            dig_sel_q <= dig_sel_d;
            seg_q     <= seg_d;
        end
    end

    assign seg       = seg_q;
    assign dig_sel   = dig_sel_q;
    assign tens      = tens_q;
    assign carry_out = carry_q;
    assign err       = err_q;
endmodule
